// File: rtl/size_convert_arbiter_if.sv
// Requester-side bus of the size-converting byte arbiter: word offers in,
// grants and the serialized byte stream out.
interface size_convert_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
);
  logic                   ENABLE;
  logic [NUM_REQ-1:0]     REQ;
  logic [32*NUM_REQ-1:0]  REQ_DATA;
  logic [2*NUM_REQ-1:0]   REQ_SIZE;
  logic [NUM_REQ-1:0]     GNT;
  logic [7:0]             DATA_OUT;
  logic                   VALID_OUT;
  logic [ID_W-1:0]        OWNER;
  logic                   IDLE_BUFFER;
  logic                   SIZE_ERR;

  modport master (
    output ENABLE, REQ, REQ_DATA, REQ_SIZE,
    input  GNT, DATA_OUT, VALID_OUT, OWNER, IDLE_BUFFER, SIZE_ERR
  );

  modport slave (
    input  ENABLE, REQ, REQ_DATA, REQ_SIZE,
    output GNT, DATA_OUT, VALID_OUT, OWNER, IDLE_BUFFER, SIZE_ERR
  );
endinterface

// File: rtl/size_convert_arbiter.sv
// Round-robin arbiter that captures a 1/2/4-byte word from the granted
// requester and streams it LSB-first, one byte per enabled PCLK cycle.
module size_convert_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 3
) (
  input logic PCLK,
  input logic RESET,
  size_convert_arbiter_if.slave bus
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic [31:0]         word_q, word_d;
  logic [1:0]          last_byte_q, last_byte_d;
  logic [1:0]          cnt_q, cnt_d;
  logic [ID_W-1:0]     last_ptr_q, last_ptr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [7:0]          data_q, data_d;
  logic                valid_q, valid_d;
  logic [ID_W-1:0]     owner_q, owner_d;
  logic                idle_q, idle_d;
  logic                size_err_q, size_err_d;

  logic                pick_valid;
  logic [ID_W-1:0]     pick_id;
  logic [NUM_REQ-1:0]  pick_hot;
  logic [31:0]         pick_data;
  logic [1:0]          pick_size;

  // Scan from the farthest slot inward so the slot right after "last" wins.
  always_comb begin
    pick_valid = 1'b0;
    pick_id    = '0;
    pick_hot   = '0;
    pick_data  = '0;
    pick_size  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (bus.REQ[i] && (i == (int'(last_ptr_q) + k) % NUM_REQ)) begin
          pick_valid  = 1'b1;
          pick_id     = ID_W'(i);
          pick_hot    = '0;
          pick_hot[i] = 1'b1;
          pick_data   = bus.REQ_DATA[32*i +: 32];
          pick_size   = bus.REQ_SIZE[2*i +: 2];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    last_byte_d = last_byte_q;
    cnt_d       = cnt_q;
    last_ptr_d  = last_ptr_q;
    gnt_d       = '0;
    data_d      = data_q;
    valid_d     = 1'b0;
    owner_d     = owner_q;
    idle_d      = idle_q;
    size_err_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.ENABLE && pick_valid) begin
          gnt_d       = pick_hot;
          owner_d     = pick_id;
          last_ptr_d  = pick_id;
          word_d      = pick_data;
          data_d      = pick_data[7:0];
          valid_d     = 1'b1;
          last_byte_d = 2'd0;
          idle_d      = 1'b1;
          // Illegal size 11 degrades to a single byte with an error pulse.
          case (pick_size)
            2'b01: begin
              last_byte_d = 2'd1;
              state_d     = SEND;
              cnt_d       = 2'd1;
              idle_d      = 1'b0;
            end
            2'b10: begin
              last_byte_d = 2'd3;
              state_d     = SEND;
              cnt_d       = 2'd1;
              idle_d      = 1'b0;
            end
            2'b11:   size_err_d = 1'b1;
            default: ;
          endcase
        end
      end

      SEND: begin
        if (bus.ENABLE) begin
          valid_d = 1'b1;
          case (cnt_q)
            2'd1:    data_d = word_q[15:8];
            2'd2:    data_d = word_q[23:16];
            2'd3:    data_d = word_q[31:24];
            default: data_d = word_q[7:0];
          endcase
          if (cnt_q == last_byte_q) begin
            state_d = IDLE;
            idle_d  = 1'b1;
            cnt_d   = 2'd0;
          end else begin
            cnt_d = cnt_q + 2'd1;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge PCLK or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      word_q      <= '0;
      last_byte_q <= '0;
      cnt_q       <= '0;
      last_ptr_q  <= ID_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      owner_q     <= '0;
      idle_q      <= 1'b1;
      size_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      last_byte_q <= last_byte_d;
      cnt_q       <= cnt_d;
      last_ptr_q  <= last_ptr_d;
      gnt_q       <= gnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      owner_q     <= owner_d;
      idle_q      <= idle_d;
      size_err_q  <= size_err_d;
    end
  end

  assign bus.GNT         = gnt_q;
  assign bus.DATA_OUT    = data_q;
  assign bus.VALID_OUT   = valid_q;
  assign bus.OWNER       = owner_q;
  assign bus.IDLE_BUFFER = idle_q;
  assign bus.SIZE_ERR    = size_err_q;

endmodule

// File: tb/tb_size_convert_arbiter.sv
// Bench for size_convert_arbiter: directed scenarios plus random traffic,
// all checked against a byte-queue round-robin reference model.
module tb_size_convert_arbiter;

  localparam int N   = 4;
  localparam int IDW = 3;

  logic PCLK = 1'b0;
  logic RESET;

  size_convert_arbiter_if #(.NUM_REQ(N), .ID_W(IDW)) bus();

  size_convert_arbiter #(.NUM_REQ(N), .ID_W(IDW)) dut (
    .PCLK  (PCLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 PCLK = ~PCLK;

  int total = 0;
  int bad   = 0;

  logic           en;
  logic [N-1:0]   reqv;
  logic [31:0]    rdata [N];
  logic [1:0]     rsize [N];
  bit             keepReq;

  logic [7:0]     mq[$];
  int             mlast;
  logic [7:0]     eData;
  logic           eValid;
  logic [N-1:0]   eGnt;
  logic [IDW-1:0] eOwner;
  logic           eIdle;
  logic           eErr;
  int             validCount;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic applyStimulus();
    bus.ENABLE = en;
    bus.REQ    = reqv;
    for (int i = 0; i < N; i++) begin
      bus.REQ_DATA[32*i +: 32] = rdata[i];
      bus.REQ_SIZE[2*i +: 2]   = rsize[i];
    end
  endtask

  task automatic modelReset();
    mq.delete();
    mlast  = N - 1;
    eData  = '0;
    eValid = 1'b0;
    eGnt   = '0;
    eOwner = '0;
    eIdle  = 1'b1;
    eErr   = 1'b0;
  endtask

  // A granted word becomes a queue of bytes; each enabled edge pops one.
  task automatic modelStep();
    int pick;
    int nb;
    logic [31:0] w;
    eGnt   = '0;
    eErr   = 1'b0;
    eValid = 1'b0;
    if (en) begin
      if (mq.size() > 0) begin
        eData  = mq.pop_front();
        eValid = 1'b1;
      end else begin
        pick = -1;
        for (int k = 1; k <= N; k++)
          if (pick < 0 && reqv[(mlast + k) % N]) pick = (mlast + k) % N;
        if (pick >= 0) begin
          w  = rdata[pick];
          nb = (rsize[pick] == 2'b01) ? 2 : (rsize[pick] == 2'b10) ? 4 : 1;
          for (int b = 0; b < nb; b++) mq.push_back(w[8*b +: 8]);
          eData      = mq.pop_front();
          eValid     = 1'b1;
          eGnt[pick] = 1'b1;
          eOwner     = IDW'(pick);
          eErr       = (rsize[pick] == 2'b11);
          mlast      = pick;
        end
      end
      eIdle = (mq.size() == 0);
    end
  endtask

  task automatic stepCycle();
    @(posedge PCLK);
    #1;
    modelStep();
    checkOutput("gnt",   32'(bus.GNT),         32'(eGnt));
    checkOutput("data",  32'(bus.DATA_OUT),    32'(eData));
    checkOutput("valid", 32'(bus.VALID_OUT),   32'(eValid));
    checkOutput("owner", 32'(bus.OWNER),       32'(eOwner));
    checkOutput("idle",  32'(bus.IDLE_BUFFER), 32'(eIdle));
    checkOutput("szerr", 32'(bus.SIZE_ERR),    32'(eErr));
    for (int i = 0; i < N; i++) begin
      if (eGnt[i] && !keepReq) begin
        reqv[i]  = 1'b0;
        rdata[i] = $urandom();
      end
    end
    applyStimulus();
    @(negedge PCLK);
  endtask

  task automatic drain(input int n);
    reqv = '0;
    en   = 1'b1;
    applyStimulus();
    repeat (n) stepCycle();
  endtask

  task automatic doReset();
    reqv  = '0;
    RESET = 1'b1;
    applyStimulus();
    modelReset();
    @(negedge PCLK);
    RESET = 1'b0;
  endtask

  initial begin
    RESET   = 1'b1;
    en      = 1'b0;
    reqv    = '0;
    keepReq = 1'b0;
    for (int i = 0; i < N; i++) begin
      rdata[i] = '0;
      rsize[i] = '0;
    end
    applyStimulus();
    modelReset();
    repeat (2) @(negedge PCLK);
    checkOutput("rst_idle",  32'(bus.IDLE_BUFFER), 32'd1);
    checkOutput("rst_valid", 32'(bus.VALID_OUT),   32'd0);
    checkOutput("rst_gnt",   32'(bus.GNT),         32'd0);
    checkOutput("rst_data",  32'(bus.DATA_OUT),    32'd0);
    RESET = 1'b0;

    // Single 4-byte word from requester 0
    en = 1'b1; reqv[0] = 1'b1; rdata[0] = 32'hA1B2C3D4; rsize[0] = 2'b10;
    applyStimulus();
    stepCycle();
    checkOutput("t1_gnt", 32'(bus.GNT), 32'h1);
    checkOutput("t1_b0",  32'(bus.DATA_OUT), 32'hD4);
    checkOutput("t1_i0",  32'(bus.IDLE_BUFFER), 32'd0);
    stepCycle(); checkOutput("t1_b1", 32'(bus.DATA_OUT), 32'hC3);
    stepCycle(); checkOutput("t1_b2", 32'(bus.DATA_OUT), 32'hB2);
    checkOutput("t1_i2", 32'(bus.IDLE_BUFFER), 32'd0);
    stepCycle(); checkOutput("t1_b3", 32'(bus.DATA_OUT), 32'hA1);
    checkOutput("t1_i3", 32'(bus.IDLE_BUFFER), 32'd1);
    drain(2);

    // All requesters held with 1-byte words, after a fresh reset
    doReset();
    keepReq = 1'b1; en = 1'b1;
    for (int i = 0; i < N; i++) begin
      rdata[i] = 32'h10 + 32'(i);
      rsize[i] = 2'b00;
    end
    reqv = '1;
    applyStimulus();
    for (int j = 0; j < 5; j++) begin
      stepCycle();
      checkOutput("t2_owner", 32'(bus.OWNER), 32'(j % N));
      checkOutput("t2_data",  32'(bus.DATA_OUT), 32'h10 + 32'(j % N));
    end
    keepReq = 1'b0;
    drain(2);

    // Two 2-byte words back to back
    reqv[1] = 1'b1; rdata[1] = 32'h0000BEEF; rsize[1] = 2'b01;
    reqv[2] = 1'b1; rdata[2] = 32'h0000CAFE; rsize[2] = 2'b01;
    applyStimulus();
    stepCycle(); checkOutput("t3_b0", 32'(bus.DATA_OUT), 32'hEF);
    stepCycle(); checkOutput("t3_b1", 32'(bus.DATA_OUT), 32'hBE);
    stepCycle(); checkOutput("t3_b2", 32'(bus.DATA_OUT), 32'hFE);
    checkOutput("t3_gnt", 32'(bus.GNT), 32'h4);
    stepCycle(); checkOutput("t3_b3", 32'(bus.DATA_OUT), 32'hCA);
    drain(2);

    // Stall for three cycles after byte1
    validCount = 0;
    reqv[0] = 1'b1; rdata[0] = 32'h11223344; rsize[0] = 2'b10;
    applyStimulus();
    for (int j = 0; j < 7; j++) begin
      en = !(j >= 2 && j <= 4);
      applyStimulus();
      stepCycle();
      if (bus.VALID_OUT) validCount++;
      if (j >= 2 && j <= 4) checkOutput("t4_hold", 32'(bus.DATA_OUT), 32'h33);
    end
    checkOutput("t4_count", 32'(validCount), 32'd4);
    drain(2);

    // Reset in the middle of a 4-byte transfer
    reqv[1] = 1'b1; rdata[1] = 32'hDEADBEEF; rsize[1] = 2'b10;
    applyStimulus();
    stepCycle();
    stepCycle();
    #2;
    RESET = 1'b1;
    #1;
    checkOutput("t5_data",  32'(bus.DATA_OUT),    32'd0);
    checkOutput("t5_valid", 32'(bus.VALID_OUT),   32'd0);
    checkOutput("t5_idle",  32'(bus.IDLE_BUFFER), 32'd1);
    checkOutput("t5_owner", 32'(bus.OWNER),       32'd0);
    modelReset();
    reqv = '0;
    reqv[3] = 1'b1; rdata[3] = 32'h000000A3; rsize[3] = 2'b00;
    reqv[0] = 1'b1; rdata[0] = 32'h000000A0; rsize[0] = 2'b00;
    applyStimulus();
    @(negedge PCLK);
    RESET = 1'b0;
    stepCycle();
    checkOutput("t5_gnt", 32'(bus.GNT), 32'h1);
    stepCycle();
    drain(2);

    // Illegal size degrades to one byte with an error pulse
    reqv[2] = 1'b1; rdata[2] = 32'h00000077; rsize[2] = 2'b11;
    applyStimulus();
    stepCycle();
    checkOutput("t6_data", 32'(bus.DATA_OUT),    32'h77);
    checkOutput("t6_err",  32'(bus.SIZE_ERR),    32'd1);
    checkOutput("t6_idle", 32'(bus.IDLE_BUFFER), 32'd1);
    stepCycle();
    checkOutput("t6_err_off", 32'(bus.SIZE_ERR), 32'd0);
    drain(2);

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      en = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < N; i++) begin
        if (!reqv[i] && $urandom_range(0, 2) == 0) begin
          reqv[i]  = 1'b1;
          rdata[i] = $urandom();
          rsize[i] = 2'($urandom_range(0, 3));
        end
      end
      applyStimulus();
      stepCycle();
    end
    drain(6);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/size_convert_arbiter.md
Name: size_convert_arbiter

Overview:
- Round-robin scheduler that shares one byte-wide serialization path between NUM_REQ requesters.
- Each requester offers a word of 1, 2 or 4 bytes. The block grants one requester, captures its word, and emits the bytes LSB-first, one per enabled PCLK cycle.
- Sits between the transaction sources and the 8-bit PHY byte stream. Outputs DATA_OUT/IDLE_BUFFER are compatible with the existing width-converter byte interface.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..8.
- ID_W, 3, width of OWNER; must be >= clog2(NUM_REQ).

Ports:
- PCLK  in  1  single clock; all state updates on the posedge.
- RESET  in  1  asynchronous, active-high reset.
- ENABLE  in  1  byte-slot enable (bit-rate strobe). When low, the block stalls.
- REQ  in  NUM_REQ  per-requester request; held high until the matching GNT bit.
- REQ_DATA  in  32*NUM_REQ  word for requester i is at [32*i+31:32*i].
- REQ_SIZE  in  2*NUM_REQ  size for requester i is at [2*i+1:2*i]. 00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes, 11 = illegal.
- GNT  out  NUM_REQ  one-hot, one-cycle pulse: the word was captured this cycle.
- DATA_OUT  out  8  current byte.
- VALID_OUT  out  1  DATA_OUT holds a new byte this cycle.
- OWNER  out  ID_W  index of the requester whose byte is on DATA_OUT.
- IDLE_BUFFER  out  1  high when no bytes of a captured word remain to be sent.
- SIZE_ERR  out  1  one-cycle pulse when a granted word carried REQ_SIZE = 11.

Behaviour:
- All outputs are registered. Async reset forces:
  - DATA_OUT = 0, VALID_OUT = 0, GNT = 0, OWNER = 0, SIZE_ERR = 0, IDLE_BUFFER = 1.
  - State = IDLE, byte counter = 0, round-robin pointer "last" = NUM_REQ-1, so requester 0 has priority first.
- FSM has two states, IDLE and SEND. Internal registers: 32-bit word, last-byte index (0, 1 or 3), byte counter.
- IDLE, at a posedge with ENABLE=1 and any REQ high:
  - Grant the first set REQ bit searching last+1, last+2, … modulo NUM_REQ.
  - Capture its data and size. Set last = granted index.
  - GNT[i] = 1, OWNER = i, DATA_OUT = byte0, VALID_OUT = 1.
  - If size is 1 byte, stay in IDLE with IDLE_BUFFER = 1. Otherwise go to SEND with counter = 1 and IDLE_BUFFER = 0.
  - Latency: REQ sampled at edge k; GNT and the first byte are visible after edge k.
- IDLE with no request, or with ENABLE=0: VALID_OUT = 0, GNT = 0; DATA_OUT and OWNER hold.
- SEND, at a posedge with ENABLE=1:
  - DATA_OUT = captured byte[counter], VALID_OUT = 1, GNT = 0.
  - If counter == last-byte index: go to IDLE with IDLE_BUFFER = 1. Otherwise increment the counter.
  - No new request is granted while in SEND; pending REQs wait.
- SEND, at a posedge with ENABLE=0: VALID_OUT = 0; counter, DATA_OUT and OWNER hold; no byte is lost.
- Back-to-back transfers: the edge that leaves SEND is followed by arbitration at the very next edge. Throughput is one byte per enabled cycle. A 1-byte grant may be followed by another grant on the next cycle.
- Byte order is LSB first: byte0 = [7:0], byte1 = [15:8], byte2 = [23:16], byte3 = [31:24].
- Illegal size 11: the word is treated as 1 byte (byte0 only), with SIZE_ERR = 1 for the grant cycle.
- A requester whose REQ drops before grant is simply not considered; no error.
- After GNT the requester may change REQ_DATA/REQ_SIZE freely. The captured copy is used.
- Reset mid-transfer aborts immediately to reset values; remaining bytes are discarded. After release, arbitration restarts from requester 0.
- GNT is never high for more than one requester, and never for two consecutive cycles to the same requester unless that requester sent a 1-byte word and is the only requester.

Test Plan:
- Reset, then REQ[0] with 32'hA1B2C3D4, size 10, ENABLE=1 -> GNT=0001 for one cycle; DATA_OUT D4, C3, B2, A1 on 4 consecutive cycles; VALID_OUT=1 for 4 cycles; IDLE_BUFFER low for the first 3 byte cycles and high after the 4th.
- All four requesters held high with 1-byte words 8'h10 + i -> GNT sequence 0, 1, 2, 3, 0, … one grant per cycle; OWNER matches; DATA_OUT 10, 11, 12, 13, 10.
- REQ[1] 2-byte 16'hBEEF with REQ[2] 2-byte 16'hCAFE pending -> EF, BE, FE, CA with no bubble; GNT[2] pulses on the FE cycle.
- 4-byte transfer with ENABLE=0 for 3 cycles after byte1 -> VALID_OUT=0 and DATA_OUT holds during the stall; byte2 and byte3 resume afterwards; total 4 valid bytes.
- RESET asserted after byte1 of a 4-byte word -> outputs take reset values asynchronously; after release with REQ[3] and REQ[0] high, GNT[0] is granted first.
- REQ[2] with size 11 and data 32'h00000077 -> single byte 77, SIZE_ERR one-cycle pulse, IDLE_BUFFER stays 1.
